// File: rtl/dup_filter_fifo.sv
// Valid/ready FIFO for dupTestT-style records with optional suppression of
// consecutive repeats of the last stored value and a saturating drop counter.
module dup_filter_fifo #(
    parameter int DATA_W     = 13,
    parameter int DEPTH      = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     dedup_en,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [DATA_W-1:0] lastKept;
    logic              lastKeptValid;

    logic empty;
    logic full;
    logic pushFire;
    logic isDup;
    logic keepPush;
    logic dropPush;
    logic popFire;

    // The extra pointer MSB separates the full case from the empty case.
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rdPtr[AW-1:0]];

    assign pushFire = in_valid && in_ready;
    assign isDup    = dedup_en && lastKeptValid && (in_data == lastKept);
    assign keepPush = pushFire && !isDup;
    assign dropPush = pushFire && isDup;
    assign popFire  = out_valid && out_ready;

    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // so pointer, count and flag updates cannot race each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            count         <= '0;
            drop_cnt      <= '0;
            lastKept      <= '0;
            lastKeptValid <= 1'b0;
        end else begin
            if (keepPush) begin
                wrPtr    <= wrPtr + 1'b1;
                lastKept <= in_data;
            end
            if (popFire) begin
                rdPtr <= rdPtr + 1'b1;
            end

            case ({keepPush, popFire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (dropPush && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end

            // Clearing has priority so the first record after re-enable is kept.
            if (!dedup_en) begin
                lastKeptValid <= 1'b0;
            end else if (keepPush) begin
                lastKeptValid <= 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; stale entries are never visible because
    // out_data is masked while empty and the pointers are reset.
    always_ff @(posedge clk) begin
        if (keepPush) begin
            mem[wrPtr[AW-1:0]] <= in_data;
        end
    end

    noPopWhenEmpty: assert property (@(posedge clk) disable iff (rst) !(popFire && empty));
    noWriteWhenFull: assert property (@(posedge clk) disable iff (rst) !(keepPush && full));
    countMatchesPtrs: assert property (@(posedge clk) disable iff (rst) count == PW'(wrPtr - rdPtr));

endmodule

// File: tb/tb_dup_filter_fifo.sv
// Directed and randomized bench for dup_filter_fifo against a queue-based
// reference model; a second instance with a 2-bit drop counter checks saturation.
module tb_dup_filter_fifo;

    localparam int DATA_W = 13;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              dedup_en;
    logic [2:0]        count;
    logic [DROP_W-1:0] drop_cnt;

    logic              inValid2;
    logic              inReady2;
    logic [DATA_W-1:0] inData2;
    logic              outValid2;
    logic [DATA_W-1:0] outData2;
    logic [2:0]        count2;
    logic [1:0]        dropCnt2;

    int testCnt = 0;
    int failCnt = 0;

    logic [DATA_W-1:0] mQ[$];
    logic [DATA_W-1:0] mLast;
    bit                mLastValid;
    int                mDrop;

    always #5 clk = ~clk;

    dup_filter_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_CNT_W(DROP_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dedup_en(dedup_en), .count(count), .drop_cnt(drop_cnt)
    );

    dup_filter_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_CNT_W(2)) dutSat (
        .clk(clk), .rst(rst),
        .in_valid(inValid2), .in_ready(inReady2), .in_data(inData2),
        .out_valid(outValid2), .out_ready(1'b0), .out_data(outData2),
        .dedup_en(1'b1), .count(count2), .drop_cnt(dropCnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mLast      = '0;
        mLastValid = 0;
        mDrop      = 0;
    endtask

    task automatic checkModel(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'(mQ.size() < DEPTH));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mQ.size() != 0));
        check({tag, ".out_data"},  32'(out_data),  (mQ.size() != 0) ? 32'(mQ[0]) : 32'd0);
        check({tag, ".count"},     32'(count),     32'(mQ.size()));
        check({tag, ".drop_cnt"},  32'(drop_cnt),  32'(mDrop));
    endtask

    // Applies one handshake cycle of the behavioural rules to the model.
    task automatic modelEdge(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit de);
        bit canPush;
        bit doPop;
        canPush = v && (mQ.size() < DEPTH);
        doPop   = r && (mQ.size() != 0);
        if (canPush) begin
            if (de && mLastValid && d == mLast) begin
                if (mDrop < (1 << DROP_W) - 1) mDrop++;
            end else begin
                mQ.push_back(d);
                mLast      = d;
                mLastValid = 1;
            end
        end
        if (!de) mLastValid = 0;
        if (doPop) void'(mQ.pop_front());
    endtask

    // Called at posedge+1; checks pre-edge state, then leaves inputs idle.
    task automatic step(input string tag, input bit v, input logic [DATA_W-1:0] d,
                        input bit r, input bit de);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        dedup_en  = de;
        #3;
        checkModel(tag);
        modelEdge(v, d, r, de);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (mQ.size() != 0) step(tag, 0, '0, 1, dedup_en);
        end
        check({tag, ".empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int sat [7] = '{1, 2, 3, 3, 3, 3, 3};
        int dropBefore;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; dedup_en = 1'b0;
        inValid2 = 1'b0; inData2 = '0;
        modelReset();
        #2;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);
        check("reset.count", 32'(count), 32'd0);
        check("reset.drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill without dedup, then drain in order.
        for (int i = 1; i <= 4; i++) step("fill", 1, DATA_W'(i), 0, 0);
        check("fill.count", 32'(count), 32'd4);
        check("fill.in_ready", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check("order.head", 32'(out_data), 32'(i));
            step("order", 0, '0, 1, 0);
        end
        check("order.count", 32'(count), 32'd0);

        // Consecutive duplicate suppression.
        step("dedup", 1, 13'h0AA, 0, 1);
        step("dedup", 1, 13'h0AA, 0, 1);
        step("dedup", 1, 13'h0AA, 0, 1);
        step("dedup", 1, 13'h0BB, 0, 1);
        step("dedup", 1, 13'h0AA, 0, 1);
        check("dedup.count", 32'(count), 32'd3);
        check("dedup.drop_cnt", 32'(drop_cnt), 32'd2);
        check("dedup.head", 32'(out_data), 32'h0AA);
        drain("dedupDrain");

        // Streaming through pointer rollover with concurrent push and pop.
        for (int i = 0; i < 10; i++) begin
            step("wrap", 1, DATA_W'(13'h100 + i), 1, 1);
            check("wrap.countMax", 32'(count <= 2), 32'd1);
        end
        drain("wrapDrain");

        // Duplicate offered while full is not accepted; after a pop it is dropped.
        step("full", 1, 13'h1FFF, 0, 1);
        step("full", 1, 13'h0001, 0, 1);
        step("full", 1, 13'h0002, 0, 1);
        step("full", 1, 13'h0003, 0, 1);
        dropBefore = mDrop;
        check("full.in_ready", 32'(in_ready), 32'd0);
        step("fullDup", 1, 13'h0003, 0, 1);
        check("fullDup.drop_cnt", 32'(drop_cnt), 32'(dropBefore));
        step("fullPop", 0, '0, 1, 1);
        step("afterPopDup", 1, 13'h0003, 0, 1);
        check("afterPopDup.drop_cnt", 32'(drop_cnt), 32'(dropBefore + 1));
        check("afterPopDup.count", 32'(count), 32'd3);
        drain("fullDrain");

        // Randomized traffic with a small value alphabet to provoke repeats.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0));
        end
        drain("randDrain");

        // Asynchronous reset mid-stream.
        rst = 1'b1;
        #2;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("pre", 1, 13'h0009, 0, 1);
        for (int i = 0; i < 5; i++) step("pre", 1, 13'h0009, 0, 1);
        step("pre", 1, 13'h0004, 0, 1);
        step("pre", 1, 13'h0005, 0, 1);
        check("pre.count", 32'(count), 32'd3);
        check("pre.drop_cnt", 32'(drop_cnt), 32'd5);
        rst = 1'b1;
        #1;
        check("async.out_valid", 32'(out_valid), 32'd0);
        check("async.count", 32'(count), 32'd0);
        check("async.drop_cnt", 32'(drop_cnt), 32'd0);
        check("async.out_data", 32'(out_data), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("postReset", 1, 13'h0005, 0, 1);
        check("postReset.count", 32'(count), 32'd1);
        check("postReset.drop_cnt", 32'(drop_cnt), 32'd0);

        // Saturating 2-bit drop counter.
        inValid2 = 1'b1;
        inData2  = 13'h0005;
        @(posedge clk);
        #1;
        check("sat.first", 32'(dropCnt2), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("sat.drop_cnt", 32'(dropCnt2), 32'(sat[i]));
        end
        check("sat.count", 32'(count2), 32'd1);
        inValid2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
